// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmitter.
//
// Contents:
//   tx_state_t          transmitter FSM state (IDLE, TRANSMIT)
//   FRAME_BITS          bits per frame on the line (10, or 11 with parity)
//   DEFAULT_BAUD_CYCLES clocks per bit, matches the receiver full-baud reload
//   IDLE_LEVEL          line level when idle and for the stop bit
//   frame_load()        builds the shift-register image for one byte
//
// Build option: define UART_TX_PARITY_EN to insert an even parity bit
// between D7 and the stop bit (external-host link only; the current
// receiver does not understand it).
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic {
        IDLE,
        TRANSMIT
    } tx_state_t;

    localparam int unsigned DEFAULT_BAUD_CYCLES = 34;
    localparam logic        IDLE_LEVEL          = 1'b1;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    // LSB goes out first: start bit, D0..D7, [parity], stop bit.
    function automatic logic [FRAME_BITS-1:0] frame_load(input logic [7:0] data);
`ifdef UART_TX_PARITY_EN
        return {IDLE_LEVEL, ^data, data, 1'b0};
`else
        return {IDLE_LEVEL, data, 1'b0};
`endif
    endfunction

endpackage

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit. A
// one-entry holding register accepts the next byte while a frame is on the
// line so consecutive frames go out with no idle gap.
//
// Parameters:
//   BAUD_CYCLES  clocks per bit period (2..63)
//
// Ports:
//   clk        in   system clock, all flops on posedge
//   rst        in   synchronous active-high reset
//   trmt       in   single-cycle request to send tx_data
//   tx_data    in   byte to send, sampled only when trmt is accepted
//   TX         out  serial line, registered, idles high
//   busy       out  high while a frame (start through stop) is on TX
//   hold_full  out  holding register occupied
//   tx_done    out  sticky, set when a frame ends with nothing following
//
// Build option: UART_TX_PARITY_EN adds an even parity bit (11-bit frame).
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_CYCLES = DEFAULT_BAUD_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       busy,
    output logic       hold_full,
    output logic       tx_done
);

    localparam logic [5:0] BAUD_RELOAD = 6'(BAUD_CYCLES - 1);
    localparam logic [3:0] LAST_BIT    = 4'(FRAME_BITS - 1);

    tx_state_t             r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [5:0]            r_baud_cnt;
    logic [3:0]            r_bit_cnt;
    logic [7:0]            r_hold;
    logic                  r_hold_full;
    logic                  r_busy;
    logic                  r_tx_done;

    logic w_shift;
    logic w_frame_end;

    assign w_shift     = (r_state == TRANSMIT) && (r_baud_cnt == 6'd0);
    assign w_frame_end = w_shift && (r_bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= {FRAME_BITS{IDLE_LEVEL}};
            r_baud_cnt  <= 6'd0;
            r_bit_cnt   <= 4'd0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_busy      <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (trmt) begin
                        r_shift    <= frame_load(tx_data);
                        r_baud_cnt <= BAUD_RELOAD;
                        r_bit_cnt  <= 4'd0;
                        r_busy     <= 1'b1;
                        r_tx_done  <= 1'b0;
                        r_state    <= TRANSMIT;
                    end
                end

                TRANSMIT: begin
                    // A request landing on the frame-end cycle with the hold
                    // empty starts the next frame directly instead.
                    if (trmt && !r_hold_full && !w_frame_end) begin
                        r_hold      <= tx_data;
                        r_hold_full <= 1'b1;
                    end

                    if (w_frame_end) begin
                        r_baud_cnt <= BAUD_RELOAD;
                        r_bit_cnt  <= 4'd0;
                        if (r_hold_full) begin
                            // Start bit follows the stop bit with no idle cycle.
                            r_shift     <= frame_load(r_hold);
                            r_hold_full <= 1'b0;
                        end else if (trmt) begin
                            r_shift <= frame_load(tx_data);
                        end else begin
                            r_shift   <= {IDLE_LEVEL, r_shift[FRAME_BITS-1:1]};
                            r_busy    <= 1'b0;
                            r_tx_done <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end else if (w_shift) begin
                        r_shift    <= {IDLE_LEVEL, r_shift[FRAME_BITS-1:1]};
                        r_baud_cnt <= BAUD_RELOAD;
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 6'd1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign TX        = r_shift[0];
    assign busy      = r_busy;
    assign hold_full = r_hold_full;
    assign tx_done   = r_tx_done;

endmodule
